select_next_hop: RTL and testbench

//  Downstream of the routing-table learning stage. On start, scans the neighbour table in shared

---
 rtl/select_next_hop_pkg.sv | 36 +++
 rtl/select_next_hop_compare.sv | 32 +++
 rtl/select_next_hop.sv | 145 ++++++++++++++
 tb/tb_select_next_hop.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/select_next_hop_pkg.sv
// ---------------------------------------------------------------------------
// select_next_hop_pkg
//  Shared definitions for the routing stages that work on the neighbour table
//  in shared memory: word width, memory-map addresses, the next-hop FSM state
//  encoding and a helper that forms a per-neighbour table address.
// ---------------------------------------------------------------------------
package select_next_hop_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int IDX_WIDTH  = 8;

  // Memory map (byte addresses, 16-bit words)
  localparam logic [15:0] NBR_COUNT_ADDR = 16'h068A;
  localparam logic [15:0] NEXTHOP_ADDR   = 16'h068C;
  localparam logic [15:0] ID_BASE        = 16'h0048;
  localparam logic [15:0] BAT_BASE       = 16'h0148;
  localparam logic [15:0] Q_BASE         = 16'h01C8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_CNT = 3'd1,
    S_CHECK  = 3'd2,
    S_LD_BAT = 3'd3,
    S_LD_Q   = 3'd4,
    S_LD_ID  = 3'd5,
    S_WR_HOP = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  // Byte address of entry idx in a table of 16-bit words starting at base.
  function automatic logic [15:0] table_addr(input logic [15:0] base,
                                             input logic [IDX_WIDTH-1:0] idx);
    return base + {7'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/select_next_hop_compare.sv
// ---------------------------------------------------------------------------
// select_next_hop_compare (hop_compare)
//  Combinational eligibility / minimum test for one neighbour.
//  Ports:
//   bat    in  16  neighbour batteryStat
//   q      in  16  neighbour qValue
//   best_q in  16  lowest qValue accepted so far
//   take   out 1   neighbour is eligible and strictly cheaper than best_q
// ---------------------------------------------------------------------------
module hop_compare
  import select_next_hop_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] MIN_BATTERY = 16'd10
) (
  input  logic [WORD_WIDTH-1:0] bat,
  input  logic [WORD_WIDTH-1:0] q,
  input  logic [WORD_WIDTH-1:0] best_q,
  output logic                  take
);

  // Strict '<' keeps the first-found neighbour on ties; since best_q starts
  // at FFFF a qValue of FFFF can never be taken.
  always_comb begin
    take = 1'b0;
    if ((bat >= MIN_BATTERY) && (q < best_q)) begin
      take = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/select_next_hop.sv
// ---------------------------------------------------------------------------
// select_next_hop
//  On start, reads NBR_COUNT, then batteryStat/qValue/neighbourID of each
//  neighbour, keeps the lowest-qValue neighbour with enough battery, writes
//  its ID (or NO_HOP) to NEXTHOP and reports the result on ports.
//  Ports:
//   clock     in  1   system clock, rising edge
//   rst       in  1   synchronous reset, active-high
//   start     in  1   one-cycle pulse; accepted in IDLE or FIN
//   address   out 16  registered byte address to shared memory
//   data_in   in  16  read data, valid the cycle after address changes
//   data_out  out 16  registered write data
//   wr_en     out 1   write strobe, one cycle per write
//   done      out 1   scan complete, held until the next accepted start
//   hop_valid out 1   an eligible neighbour was found
//   best_id   out 16  chosen neighbourID or NO_HOP
//   best_q    out 16  qValue of the chosen neighbour or FFFF
// ---------------------------------------------------------------------------
module select_next_hop
  import select_next_hop_pkg::*;
#(
  parameter int                    MAX_NEIGHBORS = 128,
  parameter logic [WORD_WIDTH-1:0] MIN_BATTERY   = 16'd10,
  parameter logic [WORD_WIDTH-1:0] NO_HOP        = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic [WORD_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  wr_en,
  output logic                  done,
  output logic                  hop_valid,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_q
);

  localparam logic [WORD_WIDTH-1:0] MAX_WORD = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [IDX_WIDTH-1:0]  MAX_IDX  = IDX_WIDTH'(MAX_NEIGHBORS);

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [WORD_WIDTH-1:0]  bat_r;
  logic [WORD_WIDTH-1:0]  q_r;
  logic                   take;

  hop_compare #(
    .MIN_BATTERY(MIN_BATTERY)
  ) u_hop_compare (
    .bat    (bat_r),
    .q      (q_r),
    .best_q (best_q),
    .take   (take)
  );

  // Scan FSM: every output is a register updated here.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= S_IDLE;
      address   <= 16'h0000;
      data_out  <= 16'h0000;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      hop_valid <= 1'b0;
      best_id   <= NO_HOP;
      best_q    <= 16'hFFFF;
      idx       <= 8'd0;
      cnt       <= 8'd0;
      bat_r     <= 16'h0000;
      q_r       <= 16'h0000;
    end else begin
      case (state)
        // FIN with start behaves exactly like IDLE with start.
        S_IDLE, S_FIN: begin
          if (start) begin
            state     <= S_LD_CNT;
            address   <= NBR_COUNT_ADDR;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            hop_valid <= 1'b0;
            best_id   <= NO_HOP;
            best_q    <= 16'hFFFF;
            idx       <= 8'd0;
          end else if (state == S_FIN) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_en <= 1'b0;
          end
        end
        S_LD_CNT: begin
          // Clamp so the 8-bit index can never wrap.
          if (data_in > MAX_WORD) begin
            cnt <= MAX_IDX;
          end else begin
            cnt <= data_in[IDX_WIDTH-1:0];
          end
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (idx == cnt) begin
            state <= S_WR_HOP;
          end else begin
            address <= table_addr(BAT_BASE, idx);
            state   <= S_LD_BAT;
          end
        end
        S_LD_BAT: begin
          bat_r   <= data_in;
          address <= table_addr(Q_BASE, idx);
          state   <= S_LD_Q;
        end
        S_LD_Q: begin
          q_r     <= data_in;
          address <= table_addr(ID_BASE, idx);
          state   <= S_LD_ID;
        end
        S_LD_ID: begin
          if (take) begin
            best_q    <= q_r;
            best_id   <= data_in;
            hop_valid <= 1'b1;
          end else begin
            best_q <= best_q;
          end
          idx   <= idx + 8'd1;
          state <= S_CHECK;
        end
        S_WR_HOP: begin
          address  <= NEXTHOP_ADDR;
          data_out <= best_id;
          wr_en    <= 1'b1;
          state    <= S_FIN;
        end
        default: begin
          state <= S_IDLE;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_select_next_hop.sv
module tb_select_next_hop;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        wr_en;
  logic        done;
  logic        hop_valid;
  logic [15:0] best_id;
  logic [15:0] best_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] id;
    logic [15:0] q;
    logic        valid;
    int          lat;
  } exp_t;

  exp_t        res_q[$];
  logic [15:0] wr_q[$];

  logic [15:0] mem [0:1023];

  select_next_hop dut (
    .clock    (clock),
    .rst      (rst),
    .start    (start),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .wr_en    (wr_en),
    .done     (done),
    .hop_valid(hop_valid),
    .best_id  (best_id),
    .best_q   (best_q)
  );

  always #5 clock = ~clock;

  // Shared memory: read data follows the registered address within the cycle.
  assign data_in = mem[address[10:1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must be to NEXTHOP and match a queued expectation.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      check("wr_addr", {16'h0, address}, 32'h068C);
      check("wr_expected", {31'h0, (wr_q.size() > 0)}, 32'h1);
      if (wr_q.size() > 0) begin
        check("wr_data", {16'h0, data_out}, {16'h0, wr_q.pop_front()});
      end
    end
  end

  function automatic logic [15:0] rd(input int byte_addr);
    return mem[byte_addr / 2];
  endfunction

  // Reference result for the current memory contents.
  function automatic exp_t ref_scan();
    exp_t e;
    int   n;
    logic [15:0] b;
    logic [15:0] qq;
    n = rd(16'h068A);
    if (n > 128) n = 128;
    e.id = 16'hFFFF; e.q = 16'hFFFF; e.valid = 1'b0; e.lat = 4 * n + 4;
    for (int i = 0; i < n; i++) begin
      b  = rd(16'h0148 + 2 * i);
      qq = rd(16'h01C8 + 2 * i);
      if (b >= 16'd10 && qq < e.q) begin
        e.q = qq; e.id = rd(16'h0048 + 2 * i); e.valid = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic set_nbr(input int i, input logic [15:0] id, input logic [15:0] bat, input logic [15:0] q);
    mem[(16'h0048 + 2 * i) / 2] = id;
    mem[(16'h0148 + 2 * i) / 2] = bat;
    mem[(16'h01C8 + 2 * i) / 2] = q;
  endtask

  task automatic set_cnt(input logic [15:0] c);
    mem[16'h068A / 2] = c;
  endtask

  // Run one scan; extra >= 0 pulses start again that many cycles into the scan.
  task automatic run_scan(input string tag, input int extra);
    exp_t e;
    exp_t got;
    int   n;
    e = ref_scan();
    res_q.push_back(e);
    wr_q.push_back(e.id);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check({tag, "_done_low"}, {31'h0, done}, 32'h0);
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      if (n == extra) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    got = res_q.pop_front();
    check({tag, "_latency"}, n, got.lat);
    check({tag, "_best_id"}, {16'h0, best_id}, {16'h0, got.id});
    check({tag, "_best_q"}, {16'h0, best_q}, {16'h0, got.q});
    check({tag, "_hop_valid"}, {31'h0, hop_valid}, {31'h0, got.valid});
    check({tag, "_one_write"}, wr_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int w = 0; w < 1024; w++) mem[w] = 16'h0000;
    repeat (2) @(negedge clock);
    check("rst_address", {16'h0, address}, 32'h0);
    check("rst_data_out", {16'h0, data_out}, 32'h0);
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_hop_valid", {31'h0, hop_valid}, 32'h0);
    check("rst_best_id", {16'h0, best_id}, 32'hFFFF);
    check("rst_best_q", {16'h0, best_q}, 32'hFFFF);
    rst = 1'b0;
    @(negedge clock);

    // 1: basic minimum
    set_cnt(16'd3);
    set_nbr(0, 16'h00A1, 16'd50, 16'd30);
    set_nbr(1, 16'h00A2, 16'd50, 16'd10);
    set_nbr(2, 16'h00A3, 16'd50, 16'd20);
    run_scan("t1", -1);
    check("t1_id_const", {16'h0, best_id}, 32'h00A2);
    repeat (3) @(negedge clock);
    check("t1_done_held", {31'h0, done}, 32'h1);

    // 2: low battery skipped (battery 9 and 10 boundary)
    set_nbr(0, 16'h00B1, 16'd4, 16'd5);
    set_nbr(1, 16'h00B2, 16'd50, 16'd10);
    set_nbr(2, 16'h00B3, 16'd50, 16'd20);
    run_scan("t2", -1);
    set_nbr(0, 16'h00C1, 16'd9, 16'd3);
    set_nbr(1, 16'h00C2, 16'd10, 16'd8);
    run_scan("t2b", -1);

    // 3: empty table
    set_cnt(16'd0);
    run_scan("t3", -1);

    // 4: tie keeps first
    set_cnt(16'd2);
    set_nbr(0, 16'h0011, 16'd50, 16'd7);
    set_nbr(1, 16'h0022, 16'd50, 16'd7);
    run_scan("t4", -1);

    // 5: reset in LD_Q of neighbour 1, then a normal scan
    set_cnt(16'd3);
    set_nbr(0, 16'h00A1, 16'd50, 16'd30);
    set_nbr(1, 16'h00A2, 16'd50, 16'd10);
    set_nbr(2, 16'h00A3, 16'd50, 16'd20);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (7) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    check("t5_wr_en", {31'h0, wr_en}, 32'h0);
    check("t5_done", {31'h0, done}, 32'h0);
    check("t5_address", {16'h0, address}, 32'h0);
    check("t5_best_id", {16'h0, best_id}, 32'hFFFF);
    repeat (4) @(negedge clock);
    check("t5_stays_idle", {31'h0, done}, 32'h0);
    run_scan("t5_after", -1);

    // 6: clamp to 128 with a stray start mid-scan, then restart from FIN
    for (int w = 16'h0048 / 2; w < 16'h02C8 / 2; w++) mem[w] = 16'($urandom_range(0, 60));
    set_cnt(16'd300);
    run_scan("t6_clamp", 10);
    set_cnt(16'd129);
    run_scan("t6_clamp129", -1);
    set_cnt(16'd128);
    run_scan("t6_exact128", -1);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
